// File: rtl/soc_memmap_pkg.sv
// SoC memory-map constants and fetch FSM encoding.
// Shared by the fetch unit, the MPU and the IMEM decode.
package soc_memmap_pkg;

   localparam logic [31:0] IMEM_BASE  = 32'h0001_0000;
   localparam logic [31:0] IMEM_LIMIT = 32'h0001_FFFF;

   typedef enum logic {
      StFetch = 1'b0,
      StFault = 1'b1
   } fetch_state_e;

   // A fetchable address is word aligned and its whole word lies inside the IMEM window.
   function automatic logic imem_fetch_ok(input logic [31:0] pc);
      return (pc[1:0] == 2'b00) && (pc >= IMEM_BASE) && (pc <= (IMEM_LIMIT - 32'd3));
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs; flush overrides push and pop.
// The head entry is always driven, so the output holds stable while the FIFO is empty.
module fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
   localparam logic [PtrW:0]   CntOne = (PtrW + 1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wptr_q, rptr_q;
   logic [PtrW:0]    count_q;
   logic             pop_ok;

   assign pop_ok = pop && (count_q != '0);
   assign rdata  = mem_q[rptr_q];
   assign count  = count_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         // Caller reserves a slot per outstanding request, so push never sees a full FIFO.
         if (push) begin
            mem_q[wptr_q] <= wdata;
            wptr_q        <= wptr_q + PtrOne;
         end
         if (pop_ok) begin
            rptr_q <= rptr_q + PtrOne;
         end
         case ({push, pop_ok})
            2'b10:   count_q <= count_q + CntOne;
            2'b01:   count_q <= count_q - CntOne;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction-fetch initiator for the 64KB IMEM: sequential word reads, one outstanding
// request, prefetch buffering, core redirects and out-of-window fault reporting.
module imem_fetch_unit
   import soc_memmap_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0001_0000,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ADDR_W     = 14
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              mem_re,
   input  logic              mem_gnt,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       instr_data,
   output logic [31:0]       instr_pc,
   output logic              fault_valid,
   output logic [31:0]       fault_pc
);

   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e    state_q, state_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [31:0]     fault_pc_q, fault_pc_d;
   logic [31:0]     req_pc_q;
   logic            inflight_q, inflight_d;
   logic [CntW-1:0] fifo_count;
   logic [63:0]     fifo_rdata;
   logic            has_room, accept, push, pop;

   assign mem_addr    = fetch_pc_q[ADDR_W+1:2];
   assign instr_valid = (fifo_count != '0);
   assign instr_pc    = fifo_rdata[63:32];
   assign instr_data  = fifo_rdata[31:0];
   assign fault_valid = (state_q == StFault);
   assign fault_pc    = fault_pc_q;

   // The in-flight word already owns a slot even though it has not landed yet.
   assign has_room = (fifo_count + CntW'(inflight_q)) < CntW'(FIFO_DEPTH);

   always_comb begin
      mem_re     = 1'b0;
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      fault_pc_d = fault_pc_q;

      if (resetn && (state_q == StFetch) && !redirect_valid && has_room &&
          imem_fetch_ok(fetch_pc_q)) begin
         mem_re = 1'b1;
      end

      accept     = mem_re && mem_gnt;
      inflight_d = accept;
      // A redirect kills the response landing this cycle by flushing instead of pushing.
      push       = inflight_q && !redirect_valid;
      pop        = instr_valid && instr_ready && !redirect_valid;

      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         state_d    = StFetch;
         fault_pc_d = '0;
      end else if (accept) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end

      // Check the address before it is ever presented, so a bad pc never reaches IMEM.
      if ((state_d == StFetch) && !imem_fetch_ok(fetch_pc_d)) begin
         state_d    = StFault;
         fault_pc_d = fetch_pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= StFetch;
         fetch_pc_q <= RESET_PC;
         fault_pc_q <= '0;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         fault_pc_q <= fault_pc_d;
         inflight_q <= inflight_d;
         if (accept) begin
            req_pc_q <= fetch_pc_q;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .flush  (redirect_valid),
      .push   (push),
      .pop    (pop),
      .wdata  ({req_pc_q, mem_rdata}),
      .rdata  (fifo_rdata),
      .count  (fifo_count)
   );

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed and random bench for imem_fetch_unit with an IMEM responder and a
// {pc, instr} scoreboard queue.
module tb_imem_fetch_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        mem_re;
   logic        mem_gnt;
   logic [13:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        fault_valid;
   logic [31:0] fault_pc;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   logic [63:0] sb[$];
   logic [31:0] exp_pc;

   // Values observed during the most recent step
   logic        s_mem_re, s_valid, s_fault;
   logic [31:0] s_fault_pc, s_instr_pc;

   always #5 clk = ~clk;

   imem_fetch_unit dut (
      .clk            (clk),
      .resetn         (resetn),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_re         (mem_re),
      .mem_gnt        (mem_gnt),
      .mem_addr       (mem_addr),
      .mem_rdata      (mem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc),
      .fault_valid    (fault_valid),
      .fault_pc       (fault_pc)
   );

   function automatic logic [31:0] imem_word(input logic [13:0] a);
      return {8'hA5, 10'h000, a} ^ {a, 18'h0_1234};
   endfunction

   function automatic logic pc_ok(input logic [31:0] pc);
      return (pc[1:0] == 2'b00) && (pc >= 32'h0001_0000) && (pc <= 32'h0001_FFFC);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample at negedge, update scoreboard, then drive the IMEM response.
   task automatic step();
      logic        acc;
      logic [13:0] addr;
      logic [63:0] e;
      @(negedge clk);
      acc        = mem_re & mem_gnt;
      addr       = mem_addr;
      s_mem_re   = mem_re;
      s_valid    = instr_valid;
      s_fault    = fault_valid;
      s_fault_pc = fault_pc;
      s_instr_pc = instr_pc;
      if (!resetn) begin
         sb.delete();
         exp_pc = 32'h0001_0000;
      end else if (redirect_valid) begin
         check("mem_re_in_redirect", 32'(mem_re), 32'd0);
         sb.delete();
         exp_pc = redirect_pc;
      end else begin
         if (!pc_ok(exp_pc)) begin
            check("mem_re_bad_pc", 32'(mem_re), 32'd0);
         end else if (acc) begin
            check("fetch_addr", 32'(mem_addr), 32'(exp_pc[15:2]));
            sb.push_back({exp_pc, imem_word(exp_pc[15:2])});
            exp_pc = exp_pc + 32'd4;
         end
         if (instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_instr", 32'(instr_valid), 32'd0);
            end else begin
               e = sb.pop_front();
               check("instr_pc", instr_pc, e[63:32]);
               check("instr_data", instr_data, e[31:0]);
            end
         end
      end
      @(posedge clk);
      #1;
      mem_rdata = acc ? imem_word(addr) : 32'hDEAD_BEEF;
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      step();
      redirect_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      resetn         = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      mem_gnt        = 1'b1;
      instr_ready    = 1'b1;
      mem_rdata      = '0;
      exp_pc         = 32'h0001_0000;

      // Reset state
      step();
      step();
      check("rst_mem_re", 32'(mem_re), 32'd0);
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_fault_valid", 32'(fault_valid), 32'd0);
      check("rst_fault_pc", fault_pc, 32'd0);
      check("rst_instr_data", instr_data, 32'd0);
      check("rst_instr_pc", instr_pc, 32'd0);

      // Streaming: first word visible two cycles after reset release
      resetn = 1'b1;
      step();
      check("c0_mem_re", 32'(s_mem_re), 32'd1);
      check("c0_valid", 32'(s_valid), 32'd0);
      step();
      check("c1_valid", 32'(s_valid), 32'd0);
      step();
      check("c2_valid", 32'(s_valid), 32'd1);
      check("c2_pc", s_instr_pc, 32'h0001_0000);
      for (int i = 0; i < 8; i++) step();

      // Back-pressure: the FIFO fills to depth and fetching stops
      instr_ready = 1'b0;
      for (int i = 0; i < 10; i++) step();
      check("stall_words", 32'(sb.size()), 32'd4);
      check("stall_mem_re", 32'(s_mem_re), 32'd0);
      check("stall_valid", 32'(s_valid), 32'd1);
      instr_ready = 1'b1;
      for (int i = 0; i < 10; i++) step();

      // Redirect with a response in flight and a concurrent pop
      redirect_to(32'h0001_0100);
      step();
      check("redir_n1_mem_re", 32'(s_mem_re), 32'd1);
      check("redir_n1_valid", 32'(s_valid), 32'd0);
      step();
      check("redir_n2_valid", 32'(s_valid), 32'd0);
      step();
      check("redir_n3_valid", 32'(s_valid), 32'd1);
      check("redir_n3_pc", s_instr_pc, 32'h0001_0100);
      for (int i = 0; i < 4; i++) step();

      // Run off the top of the window
      redirect_to(32'h0001_FFF8);
      step();
      step();
      step();
      check("top_fault_valid", 32'(s_fault), 32'd1);
      check("top_fault_pc", s_fault_pc, 32'h0002_0000);
      check("top_mem_re", 32'(s_mem_re), 32'd0);
      for (int i = 0; i < 3; i++) step();
      check("top_words_drained", 32'(sb.size()), 32'd0);
      redirect_to(32'h0001_0000);
      step();
      check("top_fault_clear", 32'(s_fault), 32'd0);
      for (int i = 0; i < 4; i++) step();

      // Misaligned and out-of-window redirects
      redirect_to(32'h0001_0002);
      step();
      check("misal_fault_valid", 32'(s_fault), 32'd1);
      check("misal_fault_pc", s_fault_pc, 32'h0001_0002);
      for (int i = 0; i < 3; i++) step();
      redirect_to(32'h0000_0000);
      step();
      check("low_fault_valid", 32'(s_fault), 32'd1);
      check("low_fault_pc", s_fault_pc, 32'h0000_0000);
      for (int i = 0; i < 3; i++) step();
      redirect_to(32'h0001_0040);
      step();
      check("low_fault_clear", 32'(s_fault), 32'd0);

      // Random grant stalls and consumer back-pressure with a reset pulse mid-stream
      for (int i = 0; i < 300; i++) begin
         mem_gnt     = 1'($urandom_range(0, 1));
         instr_ready = 1'($urandom_range(0, 1));
         resetn      = (i != 150);
         step();
      end
      resetn = 1'b0;
      step();
      resetn      = 1'b1;
      mem_gnt     = 1'b1;
      instr_ready = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!s_valid && n < 50);
      check("post_reset_first_pc", s_instr_pc, 32'h0001_0000);
      for (int i = 0; i < 5; i++) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
